// File: rtl/snake_pkg.sv
// Shared snake-game constants, food generator state encoding and LFSR step.
package snake_pkg;

  localparam int unsigned GRID_W       = 40;
  localparam int unsigned GRID_H       = 30;
  localparam int unsigned X_W          = 6;
  localparam int unsigned Y_W          = 5;
  localparam int unsigned LFSR_W       = 16;
  localparam int unsigned MAX_ATTEMPTS = 64;
  localparam int unsigned ATT_W        = 7;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    IDLE,
    DRAW,
    QUERY,
    WAIT,
    FAIL
  } fg_state_t;

  // Fibonacci step for x^16+x^14+x^13+x^11+1, shifting right.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[0] ^ q[2] ^ q[3] ^ q[5], q[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; reloads the seed on RST.
module lfsr16
  import snake_pkg::*;
(
  input  logic              clk,
  input  logic              RST,
  output logic [LFSR_W-1:0] Q
);

  always_ff @(posedge clk) begin
    if (RST) Q <= LFSR_SEED;
    else     Q <= lfsr_next(Q);
  end

endmodule

// File: rtl/food_gen.sv
// Food placement: draws random grid cells, checks them against the snake body
// and publishes the first free one, giving up after a fixed attempt budget.
module food_gen
  import snake_pkg::*;
(
  input  logic           clk,
  input  logic           RST,
  input  logic           GEN_REQ,
  output logic [X_W-1:0] QUERY_X,
  output logic [Y_W-1:0] QUERY_Y,
  output logic           QUERY_VALID,
  input  logic           OCCUPIED,
  output logic [X_W-1:0] FOOD_X,
  output logic [Y_W-1:0] FOOD_Y,
  output logic           FOOD_VALID,
  output logic           BUSY,
  output logic           FOOD_FAIL
);

  fg_state_t         state;
  logic [ATT_W-1:0]  attempts;
  logic [LFSR_W-1:0] lfsr;
  logic [X_W-1:0]    draw_x;
  logic [Y_W-1:0]    draw_y;
  logic              draw_ok;
  logic              last_draw;
  logic              budget_spent;
  logic              unused_lfsr;

  lfsr16 u_lfsr (
    .clk (clk),
    .RST (RST),
    .Q   (lfsr)
  );

  assign draw_x       = lfsr[5:0];
  assign draw_y       = lfsr[12:8];
  assign draw_ok      = (draw_x < X_W'(GRID_W)) && (draw_y < Y_W'(GRID_H));
  assign last_draw    = (attempts == ATT_W'(MAX_ATTEMPTS - 1));
  assign budget_spent = (attempts == ATT_W'(MAX_ATTEMPTS));
  assign unused_lfsr  = ^{lfsr[15:13], lfsr[7:6]};

  // QUERY_X/QUERY_Y double as the registered candidate, so they only change
  // on an in-range draw and hold otherwise.
  always_ff @(posedge clk) begin
    if (RST) begin
      state       <= IDLE;
      attempts    <= '0;
      QUERY_X     <= '0;
      QUERY_Y     <= '0;
      QUERY_VALID <= 1'b0;
      FOOD_X      <= '0;
      FOOD_Y      <= '0;
      FOOD_VALID  <= 1'b0;
      BUSY        <= 1'b0;
      FOOD_FAIL   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (GEN_REQ) begin
            FOOD_VALID <= 1'b0;
            FOOD_FAIL  <= 1'b0;
            attempts   <= '0;
            BUSY       <= 1'b1;
            state      <= DRAW;
          end
        end
        DRAW: begin
          attempts <= attempts + ATT_W'(1);
          if (draw_ok) begin
            QUERY_X     <= draw_x;
            QUERY_Y     <= draw_y;
            QUERY_VALID <= 1'b1;
            state       <= QUERY;
          end else if (last_draw) begin
            FOOD_FAIL <= 1'b1;
            BUSY      <= 1'b0;
            state     <= FAIL;
          end
        end
        QUERY: begin
          QUERY_VALID <= 1'b0;
          state       <= WAIT;
        end
        WAIT: begin
          if (!OCCUPIED) begin
            FOOD_X     <= QUERY_X;
            FOOD_Y     <= QUERY_Y;
            FOOD_VALID <= 1'b1;
            BUSY       <= 1'b0;
            state      <= IDLE;
          end else if (budget_spent) begin
            FOOD_FAIL <= 1'b1;
            BUSY      <= 1'b0;
            state     <= FAIL;
          end else begin
            state <= DRAW;
          end
        end
        FAIL:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_food_gen.sv
// Self-checking bench for food_gen: table of request scenarios checked against
// a timing model of the search, plus hand-written reset corner cases.
module tb_food_gen;
  import snake_pkg::*;

  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic       GEN_REQ = 1'b0;
  logic       OCCUPIED = 1'b0;
  logic [5:0] QUERY_X;
  logic [4:0] QUERY_Y;
  logic       QUERY_VALID;
  logic [5:0] FOOD_X;
  logic [4:0] FOOD_Y;
  logic       FOOD_VALID;
  logic       BUSY;
  logic       FOOD_FAIL;

  food_gen dut (
    .clk         (clk),
    .RST         (RST),
    .GEN_REQ     (GEN_REQ),
    .QUERY_X     (QUERY_X),
    .QUERY_Y     (QUERY_Y),
    .QUERY_VALID (QUERY_VALID),
    .OCCUPIED    (OCCUPIED),
    .FOOD_X      (FOOD_X),
    .FOOD_Y      (FOOD_Y),
    .FOOD_VALID  (FOOD_VALID),
    .BUSY        (BUSY),
    .FOOD_FAIL   (FOOD_FAIL)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_query  = 0;
  int q_base   = 0;
  int occ_n    = 0;

  logic [15:0] m_lfsr;
  logic [10:0] exp_q[$];
  logic [5:0]  exp_x;
  logic [4:0]  exp_y;
  bit          exp_fail;
  int          exp_cycles;
  int          exp_nq;
  logic [5:0]  first_x;
  logic [4:0]  first_y;

  typedef struct {
    string name;
    int    occ;
    int    req2;
    int    idle_pre;
    bit    exp_fail;
  } vec_t;
  vec_t vecs[6];

  function automatic logic [15:0] step(input logic [15:0] v);
    logic fb;
    fb = v[0] ^ v[2] ^ v[3] ^ v[5];
    return {fb, v[15:1]};
  endfunction

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    m_lfsr <= RST ? 16'hACE1 : step(m_lfsr);
  end

  // Occupancy lookup: answers one cycle after each query; first occ_n queries hit the snake.
  always @(posedge clk)
    OCCUPIED <= QUERY_VALID && ((n_query - q_base) <= occ_n);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({QUERY_X, QUERY_Y, QUERY_VALID, FOOD_X, FOOD_Y, FOOD_VALID, BUSY, FOOD_FAIL});
  endfunction

  // Predict queried cells, outcome and edges-to-finish from the LFSR value seen in DRAW.
  task automatic predict(input logic [15:0] s, input int occ);
    logic [15:0] v;
    logic [5:0]  x;
    logic [4:0]  y;
    int          draws;
    bit          fin;
    v = s; draws = 0; fin = 0;
    exp_q.delete();
    exp_cycles = 0; exp_nq = 0; exp_fail = 0; exp_x = '0; exp_y = '0;
    while (!fin) begin
      draws++;
      x = v[5:0];
      y = v[12:8];
      if (x < 6'd40 && y < 5'd30) begin
        exp_q.push_back({x, y});
        exp_nq++;
        exp_cycles += 3;
        if (exp_nq <= occ) begin
          if (draws == 64) begin exp_fail = 1; fin = 1; end
          else v = step(step(step(v)));
        end else begin
          exp_x = x; exp_y = y; fin = 1;
        end
      end else begin
        exp_cycles += 1;
        if (draws == 64) begin exp_fail = 1; fin = 1; end
        else v = step(v);
      end
    end
  endtask

  task automatic take_query();
    logic [10:0] e;
    n_query++;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_query: got %0h expected none", {QUERY_X, QUERY_Y});
    end else begin
      e = exp_q.pop_front();
      check("query_xy", 32'({QUERY_X, QUERY_Y}), 32'(e));
    end
  endtask

  // Caller sits at a negedge; the request is sampled on the next rising edge.
  task automatic run_req(input string name, input int occ, input int req2,
                         input int idle_pre, input bit tbl_fail);
    int c0;
    bit done;
    for (int i = 0; i < idle_pre; i++) begin
      @(negedge clk);
      check("idle_no_query", 32'(QUERY_VALID), 32'd0);
    end
    occ_n   = occ;
    q_base  = n_query;
    GEN_REQ = 1'b1;
    @(negedge clk);
    GEN_REQ = 1'b0;
    predict(m_lfsr, occ);
    c0 = cyc;
    check("busy_after_req", 32'(BUSY), 32'd1);
    check("valid_cleared", 32'(FOOD_VALID), 32'd0);
    done = 0;
    for (int k = 1; k <= 1000 && !done; k++) begin
      GEN_REQ = (k == req2);
      @(negedge clk);
      if (QUERY_VALID) take_query();
      if (FOOD_VALID || FOOD_FAIL) done = 1;
    end
    GEN_REQ = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no result expected result within 1000 cycles", name);
    end
    check("latency", 32'(cyc - c0), 32'(exp_cycles));
    check("food_fail", 32'(FOOD_FAIL), 32'(tbl_fail));
    check("food_valid", 32'(FOOD_VALID), 32'(!tbl_fail));
    check("busy_done", 32'(BUSY), 32'd0);
    check("query_count", 32'(n_query - q_base), 32'(exp_nq));
    check("query_budget", 32'((n_query - q_base) <= 64), 32'd1);
    if (!tbl_fail) begin
      check("food_xy", 32'({FOOD_X, FOOD_Y}), 32'({exp_x, exp_y}));
      check("food_in_grid", 32'(FOOD_X < 6'd40 && FOOD_Y < 5'd30), 32'd1);
    end
    // Hold window: no stray search, placement stays put.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (QUERY_VALID) take_query();
    end
    check("hold_busy", 32'(BUSY), 32'd0);
    check("hold_valid", 32'(FOOD_VALID), 32'(!tbl_fail));
    if (!tbl_fail) check("hold_xy", 32'({FOOD_X, FOOD_Y}), 32'({exp_x, exp_y}));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bit seen;
    bit stray;
    vecs[0] = '{"free_first",     0,    0, 0, 1'b0};
    vecs[1] = '{"free_phase7",    0,    0, 7, 1'b0};
    vecs[2] = '{"occ2_then_free", 2,    0, 3, 1'b0};
    vecs[3] = '{"req_while_busy", 0,    2, 1, 1'b0};
    vecs[4] = '{"occ1_busy_req",  1,    2, 5, 1'b0};
    vecs[5] = '{"full_board",     1000, 0, 2, 1'b1};

    RST = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 32'd0);
    check("reset_lfsr", 32'(dut.u_lfsr.Q), 32'hACE1);
    RST = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_req(vecs[i].name, vecs[i].occ, vecs[i].req2, vecs[i].idle_pre, vecs[i].exp_fail);
      if (i == 0) begin
        first_x = exp_x;
        first_y = exp_y;
      end
    end

    // RST and GEN_REQ together: reset wins, no search starts.
    RST = 1'b1;
    GEN_REQ = 1'b1;
    @(negedge clk);
    RST = 1'b0;
    GEN_REQ = 1'b0;
    check("rst_prio_outputs", all_outs(), 32'd0);
    stray = 0;
    repeat (4) begin
      @(negedge clk);
      if (QUERY_VALID || BUSY) stray = 1;
    end
    check("rst_prio_idle", 32'(stray), 32'd0);

    // Reset while waiting on the lookup answer.
    occ_n   = 1000;
    q_base  = n_query;
    GEN_REQ = 1'b1;
    @(negedge clk);
    GEN_REQ = 1'b0;
    predict(m_lfsr, 1000);
    seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (QUERY_VALID) begin
        take_query();
        seen = 1;
      end
    end
    check("mid_query_seen", 32'(seen), 32'd1);
    @(negedge clk);
    check("busy_in_wait", 32'(BUSY), 32'd1);
    RST = 1'b1;
    @(negedge clk);
    check("mid_rst_outputs", all_outs(), 32'd0);
    check("mid_rst_lfsr", 32'(dut.u_lfsr.Q), 32'hACE1);
    RST = 1'b0;
    exp_q.delete();
    run_req("post_reset_rerun", 0, 0, 0, 1'b0);
    check("rerun_matches_first", 32'({FOOD_X, FOOD_Y}), 32'({first_x, first_y}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
